// File: rtl/t03_fetch.sv
`timescale 1ns/1ps
// t03_fetch: instruction fetch stage of the t03 RV32I core.
// Holds the PC, issues word reads over a req/ack memory port, and hands each
// fetched word plus its PC to decode over a valid/ready handshake. Execute can
// redirect the PC at any time; a memory that never acks raises fetch_fault.
//
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   mem_req/mem_addr    read request (held until mem_ack) and word address
//   mem_ack/mem_rdata   read completion and instruction word
//   redirect/redirect_pc  single-cycle PC load from execute
//   inst_ready          decode accepts the presented instruction
//   inst_valid/inst/inst_pc  instruction handed to decode
//   fetch_fault         request timeout (or misaligned redirect target)
//
// Build option: define T03_FETCH_ALIGN_CHECK_EN to fault on redirect targets
// with bits [1:0] != 0; otherwise those bits are cleared when loaded.
module t03_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        inst_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W:0] TIMEOUT_LIM = (CNT_W+1)'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_VALID,
        S_FAULT
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              mem_req_q, mem_req_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic              inst_valid_q, inst_valid_d;
    logic [XLEN-1:0]   inst_q, inst_d;
    logic [XLEN-1:0]   inst_pc_q, inst_pc_d;
    logic              fault_q, fault_d;
    logic              squash_q, squash_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [CNT_W:0]    cnt_inc;
    logic              timeout_hit;
    logic              pending;
    logic [XLEN-1:0]   tgt;
    logic              misalign;

    // Redirect target handling depends on the alignment-check build option.
`ifdef T03_FETCH_ALIGN_CHECK_EN
    assign tgt      = redirect_pc;
    assign misalign = |redirect_pc[1:0];
`else
    assign tgt      = redirect_pc & ~XLEN'(3);
    assign misalign = 1'b0;
`endif

    assign cnt_inc     = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign timeout_hit = (cnt_inc >= TIMEOUT_LIM);
    // A request is still unanswered after this cycle.
    assign pending     = mem_req_q && !mem_ack;

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            fault_q      <= 1'b0;
            squash_q     <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            fault_q      <= fault_d;
            squash_q     <= squash_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state and next-output logic; redirect overrides every state.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        fault_d      = fault_q;
        squash_d     = squash_q;
        cnt_d        = cnt_q;

        if (redirect) begin
            pc_d         = tgt;
            inst_valid_d = 1'b0;
            fault_d      = 1'b0;
            if (misalign) begin
                // Keep an unanswered request up until its ack drains it.
                state_d   = S_FAULT;
                fault_d   = 1'b1;
                squash_d  = 1'b0;
                cnt_d     = '0;
                mem_req_d = pending;
            end else if (pending) begin
                // Request stays on the bus; its data will be thrown away.
                state_d  = S_REQ;
                squash_d = 1'b1;
                cnt_d    = timeout_hit ? cnt_q : cnt_inc[CNT_W-1:0];
            end else begin
                // Nothing in flight (or it completes now and is dropped).
                state_d    = S_REQ;
                mem_req_d  = 1'b1;
                mem_addr_d = tgt;
                squash_d   = 1'b0;
                cnt_d      = '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d    = S_REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_q;
                    cnt_d      = '0;
                end
                S_REQ: begin
                    if (mem_ack) begin
                        cnt_d = '0;
                        if (squash_q) begin
                            // Stale data: reissue at the redirected PC.
                            squash_d   = 1'b0;
                            mem_addr_d = pc_q;
                        end else begin
                            state_d      = S_VALID;
                            mem_req_d    = 1'b0;
                            inst_valid_d = 1'b1;
                            inst_d       = mem_rdata;
                            inst_pc_d    = pc_q;
                            pc_d         = pc_q + XLEN'(4);
                        end
                    end else if (timeout_hit) begin
                        state_d   = S_FAULT;
                        mem_req_d = 1'b0;
                        fault_d   = 1'b1;
                        squash_d  = 1'b0;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_inc[CNT_W-1:0];
                    end
                end
                S_VALID: begin
                    if (inst_ready) begin
                        state_d      = S_REQ;
                        inst_valid_d = 1'b0;
                        mem_req_d    = 1'b1;
                        mem_addr_d   = pc_q;
                        cnt_d        = '0;
                    end
                end
                S_FAULT: begin
                    // Only a drained leftover request can still be up here.
                    if (mem_req_q && mem_ack) begin
                        mem_req_d = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign inst_valid  = inst_valid_q;
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_t03_fetch.sv
`timescale 1ns/1ps
// Testbench for t03_fetch: directed scenarios followed by a randomized run
// checked against an instruction-stream model (delivered PCs follow +4 from
// the last delivered PC, or restart at the last redirect target).
module tb_t03_fetch;

    localparam int unsigned TIMEOUT  = 255;
    localparam int unsigned N_RANDOM = 4000;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    int n_checks = 0;
    int n_errors = 0;

    t03_fetch #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_ready  (inst_ready),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .fetch_fault (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a fixed function of the address; word 0 is addi x1,x0,5.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Drive a single-cycle ack carrying the word for the current mem_addr.
    task automatic ack_now();
        mem_ack   = 1'b1;
        mem_rdata = memfn(mem_addr);
        step();
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
    endtask

    task automatic ready_pulse();
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
    endtask

    task automatic redirect_pulse(input logic [31:0] t);
        redirect    = 1'b1;
        redirect_pc = t;
        step();
        redirect    = 1'b0;
    endtask

    initial begin
        logic [31:0] hold_inst, hold_pc;
        int          n;

        rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        step(); step();
        chk("rst_mem_req",    32'(mem_req),     32'd0);
        chk("rst_mem_addr",   mem_addr,         32'd0);
        chk("rst_inst_valid", 32'(inst_valid),  32'd0);
        chk("rst_inst",       inst,             32'd0);
        chk("rst_inst_pc",    inst_pc,          32'd0);
        chk("rst_fault",      32'(fetch_fault), 32'd0);

        // First fetch: ack one cycle after the request is seen.
        rst = 1'b0;
        step();
        chk("first_req",  32'(mem_req), 32'd1);
        chk("first_addr", mem_addr,     32'h0);
        step();
        chk("first_addr_hold", mem_addr, 32'h0);
        ack_now();
        chk("first_valid",  32'(inst_valid), 32'd1);
        chk("first_inst",   inst,            32'h0050_0093);
        chk("first_pc",     inst_pc,         32'h0);
        chk("first_req_lo", 32'(mem_req),    32'd0);

        // Decode stalls five cycles; the instruction must not move.
        hold_inst = inst; hold_pc = inst_pc;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", 32'(inst_valid), 32'd1);
            chk("stall_inst",  inst,            hold_inst);
            chk("stall_pc",    inst_pc,         hold_pc);
            chk("stall_noreq", 32'(mem_req),    32'd0);
        end
        ready_pulse();
        chk("next_valid_lo", 32'(inst_valid), 32'd0);
        chk("next_req",      32'(mem_req),    32'd1);
        chk("next_addr",     mem_addr,        32'h4);

        // Zero-wait fetch of 0x4, then redirect while 0x8 is outstanding.
        ack_now();
        chk("pc4_valid", 32'(inst_valid), 32'd1);
        chk("pc4_pc",    inst_pc,         32'h4);
        ready_pulse();
        chk("pc8_addr", mem_addr, 32'h8);
        redirect_pulse(32'h0000_0100);
        chk("squash_req_hold",  32'(mem_req), 32'd1);
        chk("squash_addr_hold", mem_addr,     32'h8);
        step(); step();
        chk("squash_addr_hold2", mem_addr, 32'h8);
        ack_now();
        chk("squash_no_valid", 32'(inst_valid), 32'd0);
        chk("squash_new_req",  32'(mem_req),    32'd1);
        chk("squash_new_addr", mem_addr,        32'h100);
        ack_now();
        chk("tgt_valid", 32'(inst_valid), 32'd1);
        chk("tgt_pc",    inst_pc,         32'h100);
        chk("tgt_inst",  inst,            memfn(32'h100));

        // Redirect in the same cycle as the ack of 0x104.
        ready_pulse();
        chk("pc104_addr", mem_addr, 32'h104);
        redirect    = 1'b1; redirect_pc = 32'h0000_0200;
        mem_ack     = 1'b1; mem_rdata   = memfn(32'h104);
        step();
        redirect = 1'b0; mem_ack = 1'b0;
        chk("coinc_no_valid", 32'(inst_valid), 32'd0);
        chk("coinc_req",      32'(mem_req),    32'd1);
        chk("coinc_addr",     mem_addr,        32'h200);
        ack_now();
        chk("coinc_pc",   inst_pc, 32'h200);
        chk("coinc_inst", inst,    memfn(32'h200));

        // Memory stops answering: fault after TIMEOUT request cycles.
        ready_pulse();
        n = 0;
        while (mem_req === 1'b1 && n < 400) begin
            n++;
            step();
        end
        chk("timeout_cycles", 32'(n),            32'(TIMEOUT));
        chk("timeout_fault",  32'(fetch_fault), 32'd1);
        chk("timeout_req_lo", 32'(mem_req),     32'd0);
        step(); step();
        chk("fault_sticky", 32'(fetch_fault), 32'd1);
        redirect_pulse(32'h0000_0040);
        chk("fault_clear",    32'(fetch_fault), 32'd0);
        chk("fault_recovery", mem_addr,         32'h40);
        ack_now();
        chk("recov_pc", inst_pc, 32'h40);

        // Wrap from the top of the address space.
        redirect_pulse(32'hFFFF_FFFC);
        chk("wrap_valid_lo", 32'(inst_valid), 32'd0);
        chk("wrap_req_addr", mem_addr,        32'hFFFF_FFFC);
        ack_now();
        chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
        ready_pulse();
        chk("wrap_next_addr", mem_addr, 32'h0);
        ack_now();

        // Misaligned redirect target.
        redirect_pulse(32'h0000_0102);
`ifdef T03_FETCH_ALIGN_CHECK_EN
        chk("misalign_fault", 32'(fetch_fault), 32'd1);
        chk("misalign_noreq", 32'(mem_req),     32'd0);
        redirect_pulse(32'h0000_0100);
`else
        chk("misalign_nofault", 32'(fetch_fault), 32'd0);
`endif
        chk("misalign_addr", mem_addr, 32'h100);
        ack_now();
        chk("misalign_pc", inst_pc, 32'h100);

        // Reset in the middle of an outstanding request.
        ready_pulse();
        rst = 1'b1;
        step();
        chk("midrst_req",   32'(mem_req),    32'd0);
        chk("midrst_addr",  mem_addr,        32'd0);
        chk("midrst_valid", 32'(inst_valid), 32'd0);
        rst = 1'b0;

        run_random();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Randomized traffic: random memory latency, decode stalls and redirects.
    task automatic run_random();
        logic [31:0] exp_pc    = 32'h0;
        logic        out_pend  = 1'b0;
        logic [31:0] out_addr  = '0;
        int          wait_cnt  = 0;
        int          lat       = 0;
        logic        prev_hold = 1'b0;
        logic [31:0] prev_inst = '0;
        logic [31:0] prev_pc   = '0;
        int          delivered = 0;
        logic        rdy, rdir, ack;
        logic [31:0] tgt, tgt_eff;

        for (int i = 0; i < int'(N_RANDOM); i++) begin
            step();
            chk("rnd_nofault", 32'(fetch_fault), 32'd0);
            if (mem_req) chk("rnd_align", mem_addr & 32'h3, 32'h0);
            if (out_pend) begin
                chk("rnd_req_hold",  32'(mem_req), 32'd1);
                chk("rnd_addr_hold", mem_addr,     out_addr);
            end
            if (prev_hold) begin
                chk("rnd_valid_hold", 32'(inst_valid), 32'd1);
                chk("rnd_inst_hold",  inst,            prev_inst);
                chk("rnd_pc_hold",    inst_pc,         prev_pc);
            end

            rdy  = ($urandom_range(0, 2) != 0);
            rdir = ($urandom_range(0, 19) == 0);
            tgt  = 32'($urandom_range(0, 1023)) << 2;
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hC);
`ifndef T03_FETCH_ALIGN_CHECK_EN
            tgt = tgt | 32'($urandom_range(0, 3));
`endif
            tgt_eff = tgt & ~32'h3;

            ack = 1'b0;
            if (mem_req) begin
                if (!out_pend) begin
                    lat      = $urandom_range(0, 3);
                    wait_cnt = 0;
                end
                ack = (wait_cnt == lat);
                if (!ack) wait_cnt++;
            end

            inst_ready  = rdy;
            redirect    = rdir;
            redirect_pc = tgt;
            mem_ack     = ack;
            mem_rdata   = ack ? memfn(mem_addr) : $urandom;

            if (inst_valid && rdy) begin
                chk("rnd_pc",   inst_pc, exp_pc);
                chk("rnd_inst", inst,    memfn(exp_pc));
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (rdir) exp_pc = tgt_eff;

            out_pend  = mem_req && !ack;
            out_addr  = mem_addr;
            prev_hold = inst_valid && !rdy && !rdir;
            prev_inst = inst;
            prev_pc   = inst_pc;
        end
        step();
        inst_ready = 1'b0; redirect = 1'b0; mem_ack = 1'b0;
        chk("rnd_progress", 32'(delivered > 300), 32'd1);
    endtask

endmodule

// File: doc/t03_fetch.md
Name: t03_fetch

Overview:
Instruction fetch stage for the t03 RV32I core.
- Holds the PC and issues word reads on a simple request/acknowledge memory port.
- Latches the returned word and presents it, with its PC, to decode over a valid/ready handshake. Decode is the immediate generator and the control unit.
- Execute redirects the PC on taken branches and jumps. A stuck memory is reported through a timeout fault.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
TIMEOUT, 255, cycles without mem_ack in REQ before fault (1..65535).

Ports:
clk  input  1  core clock
rst  input  1  asynchronous, active-high reset
mem_req  output  1  read request, held until mem_ack
mem_addr  output  32  word address (bits [1:0] always 0)
mem_ack  input  1  read data valid this cycle
mem_rdata  input  32  instruction word
redirect  input  1  load new PC (single-cycle pulse)
redirect_pc  input  32  redirect target
inst_ready  input  1  decode accepts inst this cycle
inst_valid  output  1  inst/inst_pc valid
inst  output  32  fetched instruction
inst_pc  output  32  address of inst
fetch_fault  output  1  fetch timeout or misaligned target

Behaviour:
Reset values (asynchronous):
- pc=RESET_PC, state=IDLE.
- mem_req=0, mem_addr=0, inst_valid=0, inst=0, inst_pc=0, fetch_fault=0.
- squash=0, timeout counter=0.
- Assertion of rst mid-transaction abandons it. No ack is expected after rst is released.

States:
- IDLE: one cycle after reset release, then go to REQ.
- REQ: mem_req=1, mem_addr=pc; counter increments each cycle.
  - On mem_ack with squash=0: inst<=mem_rdata, inst_pc<=pc, pc<=pc+4 (wraps modulo 2^32), counter cleared, go to VALID.
  - On mem_ack with squash=1: data dropped, squash cleared, counter cleared, stay in REQ. The new address is presented next cycle.
  - Counter reaching TIMEOUT without ack: go to FAULT, mem_req=0.
- VALID: inst_valid=1, mem_req=0. On inst_ready: inst_valid<=0, go to REQ next cycle.
- FAULT: fetch_fault=1, mem_req=0, inst_valid=0. Leaves only on redirect or rst.

Timing:
- Registered outputs; minimum 2 cycles per instruction with a zero-wait memory (REQ+ack, VALID+ready).
- Latency from ack to inst_valid is 1 cycle.

Redirect (highest priority, any state):
- pc<=redirect_pc, inst_valid<=0, fetch_fault<=0.
- REQ with request outstanding: mem_req and mem_addr stay stable. squash<=1 unless mem_ack is high this same cycle; in that case the data is dropped and squash stays 0. Next request uses redirect_pc.
- VALID, IDLE or FAULT: go to REQ; squash stays 0.
- Redirect coincident with inst_ready in VALID: redirect wins, and the held instruction counts as consumed.

Invariants:
- mem_addr/mem_req never change while a request is unacknowledged.
- Back-to-back redirects: last one wins.
- inst and inst_pc are stable while inst_valid=1 and inst_ready=0.

Optional Feature:
Macro T03_FETCH_ALIGN_CHECK_EN.
- Defined: redirect with redirect_pc[1:0]!=0 goes to FAULT instead of REQ, with pc<=redirect_pc and fetch_fault=1. If a request is outstanding, the pending ack is still awaited and discarded before mem_req drops. mem_req stays 1 in FAULT only until that ack.
- Undefined: redirect_pc[1:0] are forced to 0 when loaded and no fault is raised.

Test Plan:
- Reset release, memory acks 1 cycle after req with 32'h00500093 -> mem_addr=0; inst_valid rises with inst=32'h00500093, inst_pc=0; next mem_addr=4.
- inst_ready held low 5 cycles in VALID -> inst/inst_pc stable, mem_req=0; ready high -> next req at pc+4.
- Redirect to 32'h0000_0100 while req at 0x8 outstanding, ack 3 cycles later -> ack data dropped, inst_valid stays 0, next mem_addr=0x100, delivered inst_pc=0x100.
- Redirect and mem_ack same cycle -> data dropped, next mem_addr=redirect_pc, no extra ack consumed.
- No ack for TIMEOUT=255 cycles -> fetch_fault=1, mem_req=0; redirect to 0x40 -> fault clears, mem_addr=0x40.
- PC 32'hFFFF_FFFC fetched -> next mem_addr=0. With T03_FETCH_ALIGN_CHECK_EN, redirect to 0x102 -> fetch_fault=1. Without it -> mem_addr=0x100.
